// File: rtl/uart_pkg.sv
// Shared UART DTM definitions: TAP address width, address map
// and the write router's state encoding.
package uart_pkg;

  localparam int IRLENGTH = 5;

  localparam logic [IRLENGTH-1:0] ADDR_DMI = 5'h11;

  typedef enum logic {
    IDLE,
    BUSY
  } router_state_e;

  // Channel idx control sits at base+2*idx, its data word right after.
  function automatic logic [IRLENGTH-1:0] stb_addr(
    input int                  idx,
    input logic                is_data,
    input logic [IRLENGTH-1:0] base
  );
    return base + IRLENGTH'(2 * idx) + IRLENGTH'(is_data);
  endfunction

endpackage

// File: rtl/stb_out_slot.sv
// Load-and-hold output register with valid for one router target.
// Cleared by the target handshake or forcibly by a drop.
module stb_out_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  input  logic             drop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Load takes priority; a held word leaves on handshake or drop.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && (ready_i || drop_i)) begin
      valid_d = 1'b0;
    end
  end

  // Slot register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/tap_write_router.sv
// Routes TAP writes to DMI or a strobe channel's control/data port,
// with per-write acceptance timeout and sticky error flags.
module tap_write_router
  import uart_pkg::*;
#(
  parameter int                  DMI_WIDTH         = 41,
  parameter int                  NUM_STB           = 2,
  parameter int                  STB_CONTROL_WIDTH = 8,
  parameter int                  STB_DATA_WIDTH    = 32,
  parameter logic [IRLENGTH-1:0] STB_ADDR_BASE     = 5'h18,
  parameter int                  TIMEOUT_CYCLES    = 1024
) (
  input  logic                                 CLK_I,
  input  logic                                 RST_NI,
  input  logic [IRLENGTH-1:0]                  WRITE_ADDRESS_I,
  input  logic [DMI_WIDTH-1:0]                 WRITE_DATA_I,
  input  logic                                 WRITE_VALID_I,
  output logic                                 WRITE_READY_O,
  output logic                                 DMI_WRITE_VALID_O,
  input  logic                                 DMI_WRITE_READY_I,
  output logic [DMI_WIDTH-1:0]                 DMI_WRITE_DATA_O,
  output logic [NUM_STB-1:0]                   STB_CONTROL_VALID_O,
  input  logic [NUM_STB-1:0]                   STB_CONTROL_READY_I,
  output logic [NUM_STB*STB_CONTROL_WIDTH-1:0] STB_CONTROL_O,
  output logic [NUM_STB-1:0]                   STB_DATA_VALID_O,
  input  logic [NUM_STB-1:0]                   STB_DATA_READY_I,
  output logic [NUM_STB*STB_DATA_WIDTH-1:0]    STB_DATA_O,
  output logic                                 ERR_DECODE_O,
  output logic                                 ERR_TIMEOUT_O,
  input  logic                                 CLEAR_ERR_I
);

  // Slot 0 is DMI; channel i control is slot 1+2i, data is 2+2i.
  localparam int NSLOT = 2 * NUM_STB + 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  router_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_dec_q, err_dec_d;
  logic          err_to_q, err_to_d;

  logic [NSLOT-1:0] sel_vec;
  logic [NSLOT-1:0] load_vec;
  logic [NSLOT-1:0] valid_vec;
  logic [NSLOT-1:0] ready_vec;
  logic             hit;
  logic             accept;
  logic             hs;
  logic             timeout_hit;

  assign WRITE_READY_O = (state_q == IDLE);
  assign accept        = WRITE_VALID_I && WRITE_READY_O;
  assign hs            = |(valid_vec & ready_vec);
  assign timeout_hit   = TO_EN && (state_q == BUSY) && !hs
                         && (cnt_q == CNT_LAST);

  // Address decode to a one-hot slot select.
  always_comb begin
    sel_vec = '0;
    hit     = 1'b0;
    if (WRITE_ADDRESS_I == ADDR_DMI) begin
      sel_vec[0] = 1'b1;
      hit        = 1'b1;
    end
    for (int i = 0; i < NUM_STB; i++) begin
      if (WRITE_ADDRESS_I == stb_addr(i, 1'b0, STB_ADDR_BASE)) begin
        sel_vec[1+2*i] = 1'b1;
        hit            = 1'b1;
      end
      if (WRITE_ADDRESS_I == stb_addr(i, 1'b1, STB_ADDR_BASE)) begin
        sel_vec[2+2*i] = 1'b1;
        hit            = 1'b1;
      end
    end
    load_vec = accept ? sel_vec : '0;
  end

  for (genvar j = 0; j < NSLOT; j++) begin : g_slot
    if (j == 0) begin : g_dmi
      assign ready_vec[j]      = DMI_WRITE_READY_I;
      assign DMI_WRITE_VALID_O = valid_vec[j];
      stb_out_slot #(.WIDTH(DMI_WIDTH)) u_slot (
        .clk_i   (CLK_I),
        .rst_ni  (RST_NI),
        .load_i  (load_vec[j]),
        .data_i  (WRITE_DATA_I),
        .ready_i (ready_vec[j]),
        .drop_i  (timeout_hit),
        .valid_o (valid_vec[j]),
        .data_o  (DMI_WRITE_DATA_O)
      );
    end else if (j % 2 == 1) begin : g_ctl
      localparam int CH = (j - 1) / 2;
      localparam int W  = STB_CONTROL_WIDTH;
      assign ready_vec[j]            = STB_CONTROL_READY_I[CH];
      assign STB_CONTROL_VALID_O[CH] = valid_vec[j];
      stb_out_slot #(.WIDTH(W)) u_slot (
        .clk_i   (CLK_I),
        .rst_ni  (RST_NI),
        .load_i  (load_vec[j]),
        .data_i  (WRITE_DATA_I[W-1:0]),
        .ready_i (ready_vec[j]),
        .drop_i  (timeout_hit),
        .valid_o (valid_vec[j]),
        .data_o  (STB_CONTROL_O[CH*W +: W])
      );
    end else begin : g_dat
      localparam int CH = (j - 2) / 2;
      localparam int W  = STB_DATA_WIDTH;
      assign ready_vec[j]         = STB_DATA_READY_I[CH];
      assign STB_DATA_VALID_O[CH] = valid_vec[j];
      stb_out_slot #(.WIDTH(W)) u_slot (
        .clk_i   (CLK_I),
        .rst_ni  (RST_NI),
        .load_i  (load_vec[j]),
        .data_i  (WRITE_DATA_I[W-1:0]),
        .ready_i (ready_vec[j]),
        .drop_i  (timeout_hit),
        .valid_o (valid_vec[j]),
        .data_o  (STB_DATA_O[CH*W +: W])
      );
    end
  end

  // Next state, stall counter and sticky errors; a new error beats clear.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_dec_d = err_dec_q;
    err_to_d  = err_to_q;
    if (CLEAR_ERR_I) begin
      err_dec_d = 1'b0;
      err_to_d  = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (hit) begin
            state_d = BUSY;
            cnt_d   = '0;
          end else begin
            err_dec_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (hs) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d  = IDLE;
          err_to_d = 1'b1;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_dec_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_dec_q <= err_dec_d;
      err_to_q  <= err_to_d;
    end
  end

  assign ERR_DECODE_O  = err_dec_q;
  assign ERR_TIMEOUT_O = err_to_q;

endmodule
